hazard_stall_unit: RTL and testbench
====================================

// Module: hazard_stall_unit
// PURPOSE
//  Interlock side of the pipeline hazard logic; works alongside ForwardControl.
//  - ForwardControl picks bypass sources for hazards that forwarding can resolve.
//  - This block detects the hazards forwarding cannot resolve: load-use, and branch
//    operands that are not yet ready for the ID-stage compare.
//  - It freezes PC and IF/ID, inserts bubbles into ID/EX, flushes IF/ID on taken
//    branches, and keeps saturating stall and flush counters.
// PARAMETERS
//  CNT_W          16  width of the performance counters
//  BR_LOAD_STALLS 2   stall cycles for a branch that depends on a load in EX (1..3)
// PORTS
//  clk             in   1      pipeline clock
//  rst_n           in   1      reset; synchronous, active-low
//  ID_rs, ID_rt    in   5      source register numbers of the instruction in ID
//  ID_usesRs/Rt    in   1      the instruction in ID actually reads rs / rt
//  ID_isBranch     in   1      the instruction in ID is a beq/bne, compared in ID
//  branchTaken     in   1      the ID branch compare resolved as taken
//  ID_EX_memRead   in   1      the instruction in EX is a load
//  ID_EX_regWrite  in   1      the instruction in EX writes a register
//  ID_EX_writeReg  in   5      destination of the EX instruction (after the RegDst mux)
//  EX_MEM_memRead  in   1      the instruction in MEM is a load
//  EX_MEM_writeReg in   5      destination of the MEM instruction
//  PC_write        out  1      1 = the PC may update
//  IF_ID_write     out  1      1 = the IF/ID register may load
//  ID_EX_bubble    out  1      1 = zero the ID/EX control fields (insert a nop)
//  IF_ID_flush     out  1      1 = squash the fetched instruction (taken branch)
//  stall_cycles    out  CNT_W  saturating count of stalled cycles
//  flush_count     out  CNT_W  saturating count of flushes
// BEHAVIOUR
//  - match(r): r != 0, and (ID_usesRs && r == ID_rs, or ID_usesRt && r == ID_rt).
//  - Hazard classes, checked in this priority order:
//    BR_LOAD   ID_isBranch & ID_EX_memRead & match(ID_EX_writeReg)      -> BR_LOAD_STALLS
//    LOAD_USE  !ID_isBranch & ID_EX_memRead & match(ID_EX_writeReg)     -> 1 stall
//    BR_ALU    ID_isBranch & ID_EX_regWrite & !ID_EX_memRead
//              & match(ID_EX_writeReg)                                  -> 1 stall
//    BR_MEM    ID_isBranch & EX_MEM_memRead & match(EX_MEM_writeReg)    -> 1 stall
//  - FSM state: RUN, or HOLD with a 2-bit remaining counter rem.
//  - stall = (state == RUN & hazard) | (state == HOLD).
//    Same-cycle combinational response; the first stall cycle has zero latency.
//  - RUN, hazard with N stalls: N == 1 -> stay RUN; N > 1 -> HOLD with rem = N-1.
//  - HOLD: rem decrements each cycle; rem == 1 -> RUN on the next edge.
//    Detection is ignored while in HOLD; the counter alone sets the stall length.
//  - While stall: PC_write = 0, IF_ID_write = 0, ID_EX_bubble = 1.
//  - Otherwise: PC_write = 1, IF_ID_write = 1, ID_EX_bubble = 0.
//  - IF_ID_flush = branchTaken & !stall.
//    branchTaken is ignored while stalled (operands are stale).
//  - stall_cycles increments on each clock edge where stall = 1.
//    flush_count increments on each edge where IF_ID_flush = 1.
//    Both hold at 2^CNT_W-1 and never wrap.
//  - Reset (rst_n = 0 at a clock edge): state = RUN, rem = 0, counters = 0.
//    While rst_n = 0: PC_write = 1, IF_ID_write = 1, ID_EX_bubble = 0, IF_ID_flush = 0.
//    Reset during HOLD abandons the stall immediately.
//  - X on inputs with usesRs/usesRt = 0 must not cause a stall.
// STRUCTURE
//  - pipeline_pkg holds: the hazard class encoding (NONE, LOAD_USE, BR_ALU, BR_MEM,
//    BR_LOAD), the FSM state encoding, and REG_ZERO = 5'd0.
//  - Sub-module hazard_detect: combinational comparators, output = class + N.
//    The top level holds the FSM, the output decode and the counters.
// TESTING
//  1 lw $2 in EX, add reads $2 in ID -> one cycle with PC_write = 0, IF_ID_write = 0,
//    ID_EX_bubble = 1; stall_cycles 0 -> 1.
//  2 lw $2 in EX, beq reads $2 in ID -> stall for exactly 2 cycles (default);
//    no flush during the stall; then beq taken -> IF_ID_flush = 1 for 1 cycle;
//    flush_count = 1.
//  3 add $3 in EX, beq reads $3 -> 1 stall. lw $0 in EX, add reads $0 -> no stall.
//    ID_usesRt = 0 with a matching rt -> no stall.
//  4 rst_n = 0 in the first HOLD cycle of case 2 -> the next cycle is RUN; outputs
//    are non-stall and the counters read 0.
//  5 Force stall_cycles to 16'hFFFE, hold a hazard for 3 cycles -> the counter reads
//    16'hFFFF and stays there.

Source files
------------

// File: rtl/hazard_stall_unit_pkg.sv
// Shared encodings for the pipeline hazard interlock: hazard classes, FSM states, register zero.
// Latency: n/a (types and pure functions only); backpressure: n/a.
package pipeline_pkg;

    localparam logic [4:0] REG_ZERO = 5'd0;

    typedef enum logic [2:0] {
        HZ_NONE     = 3'd0,
        HZ_LOAD_USE = 3'd1,
        HZ_BR_ALU   = 3'd2,
        HZ_BR_MEM   = 3'd3,
        HZ_BR_LOAD  = 3'd4
    } hz_class_e;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HOLD = 1'b1
    } state_e;

    // Register zero never carries a dependency; unused source fields are masked
    // before the compare so garbage in them cannot raise a hazard.
    function automatic logic reg_match(
        input logic [4:0] r,
        input logic [4:0] rs,
        input logic       uses_rs,
        input logic [4:0] rt,
        input logic       uses_rt
    );
        return (r != REG_ZERO) && ((uses_rs && (r == rs)) || (uses_rt && (r == rt)));
    endfunction

endpackage

// File: rtl/hazard_stall_unit_if.sv
// Pipeline-to-interlock signal bundle; master is the pipeline, slave is the hazard unit.
// Latency: n/a (wiring only); backpressure: none, the unit answers combinationally.
interface hazard_stall_unit_if #(
    parameter int CNT_W = 16
);
    logic [4:0]       ID_rs;
    logic [4:0]       ID_rt;
    logic             ID_usesRs;
    logic             ID_usesRt;
    logic             ID_isBranch;
    logic             branchTaken;
    logic             ID_EX_memRead;
    logic             ID_EX_regWrite;
    logic [4:0]       ID_EX_writeReg;
    logic             EX_MEM_memRead;
    logic [4:0]       EX_MEM_writeReg;
    logic             PC_write;
    logic             IF_ID_write;
    logic             ID_EX_bubble;
    logic             IF_ID_flush;
    logic [CNT_W-1:0] stall_cycles;
    logic [CNT_W-1:0] flush_count;

    modport master (
        output ID_rs, ID_rt, ID_usesRs, ID_usesRt, ID_isBranch, branchTaken,
               ID_EX_memRead, ID_EX_regWrite, ID_EX_writeReg,
               EX_MEM_memRead, EX_MEM_writeReg,
        input  PC_write, IF_ID_write, ID_EX_bubble, IF_ID_flush,
               stall_cycles, flush_count
    );

    modport slave (
        input  ID_rs, ID_rt, ID_usesRs, ID_usesRt, ID_isBranch, branchTaken,
               ID_EX_memRead, ID_EX_regWrite, ID_EX_writeReg,
               EX_MEM_memRead, EX_MEM_writeReg,
        output PC_write, IF_ID_write, ID_EX_bubble, IF_ID_flush,
               stall_cycles, flush_count
    );

endinterface

// File: rtl/hazard_stall_unit_hazard_detect.sv
// Classifies the ID-stage hazard that forwarding cannot cover and reports its stall length.
// Latency: 0 (purely combinational); backpressure: none.
module hazard_detect
    import pipeline_pkg::*;
#(
    parameter int BR_LOAD_STALLS = 2
) (
    input  logic [4:0] id_rs,
    input  logic [4:0] id_rt,
    input  logic       id_uses_rs,
    input  logic       id_uses_rt,
    input  logic       id_is_branch,
    input  logic       ex_mem_read,
    input  logic       ex_reg_write,
    input  logic [4:0] ex_write_reg,
    input  logic       mem_mem_read,
    input  logic [4:0] mem_write_reg,
    output hz_class_e  hz_class,
    output logic [1:0] hz_stalls
);

    localparam logic [1:0] BR_LOAD_N = 2'(BR_LOAD_STALLS);

    logic ex_match;
    logic mem_match;

    always_comb begin
        ex_match  = reg_match(ex_write_reg, id_rs, id_uses_rs, id_rt, id_uses_rt);
        mem_match = reg_match(mem_write_reg, id_rs, id_uses_rs, id_rt, id_uses_rt);
        hz_class  = HZ_NONE;
        hz_stalls = 2'd0;
        // Branches compare in ID, so a load in EX needs the longest wait.
        if (id_is_branch && ex_mem_read && ex_match) begin
            hz_class  = HZ_BR_LOAD;
            hz_stalls = BR_LOAD_N;
        end else if (!id_is_branch && ex_mem_read && ex_match) begin
            hz_class  = HZ_LOAD_USE;
            hz_stalls = 2'd1;
        end else if (id_is_branch && ex_reg_write && !ex_mem_read && ex_match) begin
            hz_class  = HZ_BR_ALU;
            hz_stalls = 2'd1;
        end else if (id_is_branch && mem_mem_read && mem_match) begin
            hz_class  = HZ_BR_MEM;
            hz_stalls = 2'd1;
        end
    end

endmodule

// File: rtl/hazard_stall_unit.sv
// Pipeline interlock: freezes PC/IF-ID, bubbles ID/EX, flushes on taken branches, counts both.
// Latency: 0 for the first stall cycle, multi-cycle stalls held by FSM; backpressure: drives it.
module hazard_stall_unit
    import pipeline_pkg::*;
#(
    parameter int CNT_W          = 16,
    parameter int BR_LOAD_STALLS = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    hazard_stall_unit_if.slave  bus
);

    hz_class_e        hz_class;
    logic [1:0]       hz_stalls;
    state_e           state_q, state_d;
    logic [1:0]       rem_q, rem_d;
    logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;
    logic [CNT_W-1:0] flush_count_q, flush_count_d;
    logic             stall;
    logic             flush;

    hazard_detect #(
        .BR_LOAD_STALLS (BR_LOAD_STALLS)
    ) u_detect (
        .id_rs         (bus.ID_rs),
        .id_rt         (bus.ID_rt),
        .id_uses_rs    (bus.ID_usesRs),
        .id_uses_rt    (bus.ID_usesRt),
        .id_is_branch  (bus.ID_isBranch),
        .ex_mem_read   (bus.ID_EX_memRead),
        .ex_reg_write  (bus.ID_EX_regWrite),
        .ex_write_reg  (bus.ID_EX_writeReg),
        .mem_mem_read  (bus.EX_MEM_memRead),
        .mem_write_reg (bus.EX_MEM_writeReg),
        .hz_class      (hz_class),
        .hz_stalls     (hz_stalls)
    );

    always_comb begin
        // In HOLD the remaining count alone decides; fresh detection is ignored.
        stall = (state_q == ST_HOLD) || (hz_class != HZ_NONE);
        flush = bus.branchTaken && !stall;
        if (!rst_n) begin
            stall = 1'b0;
            flush = 1'b0;
        end

        state_d = state_q;
        rem_d   = rem_q;
        case (state_q)
            ST_RUN: begin
                if ((hz_class != HZ_NONE) && (hz_stalls > 2'd1)) begin
                    state_d = ST_HOLD;
                    rem_d   = hz_stalls - 2'd1;
                end
            end
            ST_HOLD: begin
                rem_d = rem_q - 2'd1;
                if (rem_q <= 2'd1) begin
                    state_d = ST_RUN;
                    rem_d   = 2'd0;
                end
            end
            default: begin
                state_d = ST_RUN;
                rem_d   = 2'd0;
            end
        endcase

        stall_cycles_d = stall_cycles_q;
        if (stall && (stall_cycles_q != {CNT_W{1'b1}}))
            stall_cycles_d = stall_cycles_q + CNT_W'(1);
        flush_count_d = flush_count_q;
        if (flush && (flush_count_q != {CNT_W{1'b1}}))
            flush_count_d = flush_count_q + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q        <= ST_RUN;
            rem_q          <= 2'd0;
            stall_cycles_q <= '0;
            flush_count_q  <= '0;
        end else begin
            state_q        <= state_d;
            rem_q          <= rem_d;
            stall_cycles_q <= stall_cycles_d;
            flush_count_q  <= flush_count_d;
        end
    end

    assign bus.PC_write     = !stall;
    assign bus.IF_ID_write  = !stall;
    assign bus.ID_EX_bubble = stall;
    assign bus.IF_ID_flush  = flush;
    assign bus.stall_cycles = stall_cycles_q;
    assign bus.flush_count  = flush_count_q;

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Directed bench for the hazard interlock with a stall-debt model checked every cycle.
// A second 2-bit-counter instance shares the stimulus to exercise counter saturation.
module tb_hazard_stall_unit;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    hazard_stall_unit_if #(.CNT_W(16)) bus ();
    hazard_stall_unit_if #(.CNT_W(2))  sat_bus ();

    hazard_stall_unit #(.CNT_W(16), .BR_LOAD_STALLS(2)) dut (
        .clk (clk), .rst_n (rst_n), .bus (bus)
    );
    hazard_stall_unit #(.CNT_W(2), .BR_LOAD_STALLS(2)) dut_sat (
        .clk (clk), .rst_n (rst_n), .bus (sat_bus)
    );

    assign sat_bus.ID_rs           = bus.ID_rs;
    assign sat_bus.ID_rt           = bus.ID_rt;
    assign sat_bus.ID_usesRs       = bus.ID_usesRs;
    assign sat_bus.ID_usesRt       = bus.ID_usesRt;
    assign sat_bus.ID_isBranch     = bus.ID_isBranch;
    assign sat_bus.branchTaken     = bus.branchTaken;
    assign sat_bus.ID_EX_memRead   = bus.ID_EX_memRead;
    assign sat_bus.ID_EX_regWrite  = bus.ID_EX_regWrite;
    assign sat_bus.ID_EX_writeReg  = bus.ID_EX_writeReg;
    assign sat_bus.EX_MEM_memRead  = bus.EX_MEM_memRead;
    assign sat_bus.EX_MEM_writeReg = bus.EX_MEM_writeReg;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: owed stall cycles plus unbounded event counts, clipped on compare.
    int     m_left    = 0;
    longint m_stalls  = 0;
    longint m_flushes = 0;

    function automatic int need();
        logic ex_m, mem_m;
        ex_m  = (bus.ID_EX_writeReg != 5'd0) &&
                ((bus.ID_usesRs && bus.ID_EX_writeReg == bus.ID_rs) ||
                 (bus.ID_usesRt && bus.ID_EX_writeReg == bus.ID_rt));
        mem_m = (bus.EX_MEM_writeReg != 5'd0) &&
                ((bus.ID_usesRs && bus.EX_MEM_writeReg == bus.ID_rs) ||
                 (bus.ID_usesRt && bus.EX_MEM_writeReg == bus.ID_rt));
        if (bus.ID_isBranch && bus.ID_EX_memRead && ex_m) return 2;
        if (!bus.ID_isBranch && bus.ID_EX_memRead && ex_m) return 1;
        if (bus.ID_isBranch && bus.ID_EX_regWrite && !bus.ID_EX_memRead && ex_m) return 1;
        if (bus.ID_isBranch && bus.EX_MEM_memRead && mem_m) return 1;
        return 0;
    endfunction

    function automatic logic exp_stall();
        return rst_n && ((m_left > 0) || (need() > 0));
    endfunction

    function automatic logic exp_flush();
        return rst_n && bus.branchTaken && !exp_stall();
    endfunction

    always @(posedge clk) begin
        if (!rst_n) begin
            m_left    = 0;
            m_stalls  = 0;
            m_flushes = 0;
        end else begin
            if (exp_stall()) m_stalls++;
            if (exp_flush()) m_flushes++;
            if (m_left > 0) m_left--;
            else if (need() > 0) m_left = need() - 1;
        end
    end

    always @(negedge clk) begin
        check("model_pc_write",    bus.PC_write,         !exp_stall());
        check("model_ifid_write",  bus.IF_ID_write,      !exp_stall());
        check("model_bubble",      bus.ID_EX_bubble,     exp_stall());
        check("model_flush",       bus.IF_ID_flush,      exp_flush());
        check("model_stall_cnt",   bus.stall_cycles,     (m_stalls > 65535) ? 65535 : m_stalls);
        check("model_flush_cnt",   bus.flush_count,      (m_flushes > 65535) ? 65535 : m_flushes);
        check("model_sat_stall",   sat_bus.stall_cycles, (m_stalls > 3) ? 3 : m_stalls);
    end

    task automatic drive(input logic br, input logic tk,
                         input logic [4:0] rs, input logic urs,
                         input logic [4:0] rt, input logic urt,
                         input logic exmr, input logic exrw, input logic [4:0] exwr,
                         input logic memmr, input logic [4:0] memwr);
        bus.ID_isBranch     = br;
        bus.branchTaken     = tk;
        bus.ID_rs           = rs;
        bus.ID_usesRs       = urs;
        bus.ID_rt           = rt;
        bus.ID_usesRt       = urt;
        bus.ID_EX_memRead   = exmr;
        bus.ID_EX_regWrite  = exrw;
        bus.ID_EX_writeReg  = exwr;
        bus.EX_MEM_memRead  = memmr;
        bus.EX_MEM_writeReg = memwr;
    endtask

    task automatic nop();
        drive(0, 0, 5'd0, 0, 5'd0, 0, 0, 0, 5'd0, 0, 5'd0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        nop();
        repeat (2) tick();
        @(negedge clk);
        check("rst_pc_write",  bus.PC_write, 1);
        check("rst_bubble",    bus.ID_EX_bubble, 0);
        check("rst_stall_cnt", bus.stall_cycles, 0);

        // lw $2 in EX, add reads $2
        tick();
        rst_n = 1'b1;
        drive(0, 0, 5'd2, 1, 5'd9, 1, 1, 1, 5'd2, 0, 5'd0);
        @(negedge clk);
        check("lu_pc_write",   bus.PC_write, 0);
        check("lu_ifid_write", bus.IF_ID_write, 0);
        check("lu_bubble",     bus.ID_EX_bubble, 1);
        check("lu_cnt_before", bus.stall_cycles, 0);
        tick();
        nop();
        @(negedge clk);
        check("lu_cnt_after",  bus.stall_cycles, 1);
        check("lu_released",   bus.PC_write, 1);

        // lw $2 in EX, taken beq reads $2: two stalls, then a single flush
        tick();
        drive(1, 1, 5'd2, 1, 5'd5, 1, 1, 1, 5'd2, 0, 5'd0);
        @(negedge clk);
        check("brl_stall1",  bus.ID_EX_bubble, 1);
        check("brl_noflush1", bus.IF_ID_flush, 0);
        tick();
        drive(1, 1, 5'd2, 1, 5'd5, 1, 0, 0, 5'd0, 1, 5'd2);
        @(negedge clk);
        check("brl_stall2",  bus.PC_write, 0);
        check("brl_noflush2", bus.IF_ID_flush, 0);
        tick();
        drive(1, 1, 5'd2, 1, 5'd5, 1, 0, 0, 5'd0, 0, 5'd0);
        @(negedge clk);
        check("brl_run",     bus.PC_write, 1);
        check("brl_flush",   bus.IF_ID_flush, 1);
        check("brl_cnt",     bus.stall_cycles, 3);
        tick();
        nop();
        @(negedge clk);
        check("brl_flush_end", bus.IF_ID_flush, 0);
        check("brl_flush_cnt", bus.flush_count, 1);

        // add $3 in EX, beq reads $3
        tick();
        drive(1, 0, 5'd3, 1, 5'd0, 0, 0, 1, 5'd3, 0, 5'd0);
        @(negedge clk);
        check("bralu_stall", bus.ID_EX_bubble, 1);
        // lw $0 in EX, add reads $0
        tick();
        drive(0, 0, 5'd0, 1, 5'd0, 1, 1, 1, 5'd0, 0, 5'd0);
        @(negedge clk);
        check("r0_nostall", bus.ID_EX_bubble, 0);
        // rt matches the load but is not read
        tick();
        drive(0, 0, 5'd7, 1, 5'd2, 0, 1, 1, 5'd2, 0, 5'd0);
        @(negedge clk);
        check("unused_rt_nostall", bus.ID_EX_bubble, 0);
        // lw $4 in MEM, beq reads $4
        tick();
        drive(1, 0, 5'd4, 1, 5'd0, 0, 0, 1, 5'd6, 1, 5'd4);
        @(negedge clk);
        check("brmem_stall", bus.ID_EX_bubble, 1);
        tick();
        nop();
        @(negedge clk);
        check("brmem_cnt", bus.stall_cycles, 5);

        // reset in the first HOLD cycle
        tick();
        drive(1, 1, 5'd2, 1, 5'd5, 1, 1, 1, 5'd2, 0, 5'd0);
        @(negedge clk);
        check("rh_stall", bus.ID_EX_bubble, 1);
        tick();
        rst_n = 1'b0;
        @(negedge clk);
        check("rh_rst_pc",    bus.PC_write, 1);
        check("rh_rst_flush", bus.IF_ID_flush, 0);
        tick();
        rst_n = 1'b1;
        nop();
        @(negedge clk);
        check("rh_run_pc",    bus.PC_write, 1);
        check("rh_run_bub",   bus.ID_EX_bubble, 0);
        check("rh_stall_cnt", bus.stall_cycles, 0);
        check("rh_flush_cnt", bus.flush_count, 0);

        // hold a load-use hazard for 5 cycles: the 2-bit counter must stick at 3
        tick();
        drive(0, 0, 5'd2, 1, 5'd9, 1, 1, 1, 5'd2, 0, 5'd0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("hold_stall", bus.ID_EX_bubble, 1);
            tick();
        end
        nop();
        @(negedge clk);
        check("sat_big_cnt",   bus.stall_cycles, 5);
        check("sat_small_cnt", sat_bus.stall_cycles, 3);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
